cdb_arbiter: RTL

//   Common Data Bus arbiter: collects result requests from N issuers (ALU, LSU, BRU, ...)
//   and grants one per cycle, round-robin. Registers the winner onto the CDB, which is

---
 rtl/cdb_arbiter_pkg.sv | 26 ++
 rtl/cdb_arbiter_rr_arbiter.sv | 49 ++++
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared core constants for the Common Data Bus (CDB) arbiter.
// Contents:
//   - Default result width, ROB depth and ROB tag width.
//   - Issuer indices. These also set each issuer's port position on the arbiter.
//   - Field widths of one CDB broadcast.
package cdb_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ROB_ENTRY      = 4;
  localparam int ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY);

  // Issuer slots on the CDB
  localparam int ISR_ALU      = 0;
  localparam int ISR_LSU      = 1;
  localparam int ISR_BRU      = 2;
  localparam int ISR_MUL      = 3;
  localparam int ISR_NUM      = 4;
  localparam int ISR_NUM_LOG2 = $clog2(ISR_NUM);

  // Broadcast layout, LSB first: data, ROB tag, source index
  localparam int CDB_DATA_LSB = 0;
  localparam int CDB_ID_LSB   = DATA_WIDTH;
  localparam int CDB_SRC_LSB  = DATA_WIDTH + ROB_ENTRY_LOG2;
  localparam int CDB_WIDTH    = DATA_WIDTH + ROB_ENTRY_LOG2 + ISR_NUM_LOG2;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter with a one-hot grant output.
// Ports:
//   CLK, RSTN  clock and asynchronous active-low reset
//   req        per-requester request
//   enable     when low, no grant is given and the pointer holds
//   grant      one-hot grant; combinational from req, enable and the pointer
// The search starts at the pointer. After a grant to k the pointer moves to k+1.
// After the last requester it wraps to 0, so the winner drops to the lowest priority.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  logic [PW-1:0] idx;
  int            pos;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int off = 0; off < N; off++) begin
      pos = int'(ptr_q) + off;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = (pos == N - 1) ? '0 : PW'(pos + 1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter.
// Collects result requests from ISR_NUM function-unit issuers and grants one
// issuer per cycle, round-robin. The winner's result goes into a register, and
// that register drives the CDB broadcast.
//
// Handshake (valid/ready semantics):
//   Issuer side:  a transfer occurs when isr_request[i] & isr_grant[i].
//                 While its request is high and not yet granted, an issuer keeps
//                 its data and id stable.
//   CDB side:     a transfer occurs when cdb_valid & cdb_ready.
//                 While cdb_valid=1 and cdb_ready=0, all cdb_* outputs hold.
//
// Ports:
//   CLK, RSTN    clock (rising edge) and asynchronous active-low reset
//   isr_request  per-issuer request
//   isr_data     per-issuer result; issuer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   isr_id       per-issuer ROB tag, packed the same way
//   isr_grant    one-hot grant, combinational in the same cycle
//   flush        drops the broadcast in flight and blocks granting this cycle
//   cdb_valid, cdb_data, cdb_id, cdb_src  registered broadcast
//   cdb_ready    the ROB accepts the broadcast this cycle
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int ISR_NUM        = cdb_arbiter_pkg::ISR_NUM,
  parameter  int DATA_WIDTH     = cdb_arbiter_pkg::DATA_WIDTH,
  parameter  int ROB_ENTRY      = cdb_arbiter_pkg::ROB_ENTRY,
  localparam int ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY),
  localparam int ISR_NUM_LOG2   = $clog2(ISR_NUM)
) (
  input  logic                             CLK,
  input  logic                             RSTN,
  input  logic [ISR_NUM-1:0]               isr_request,
  input  logic [ISR_NUM*DATA_WIDTH-1:0]    isr_data,
  input  logic [ISR_NUM*ROB_ENTRY_LOG2-1:0] isr_id,
  output logic [ISR_NUM-1:0]               isr_grant,
  input  logic                             flush,
  output logic                             cdb_valid,
  output logic [DATA_WIDTH-1:0]            cdb_data,
  output logic [ROB_ENTRY_LOG2-1:0]        cdb_id,
  output logic [ISR_NUM_LOG2-1:0]          cdb_src,
  input  logic                             cdb_ready
);

  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [ROB_ENTRY_LOG2-1:0] id_q, id_d;
  logic [ISR_NUM_LOG2-1:0]   src_q, src_d;

  logic                      slot_free;
  logic                      arb_enable;
  logic                      any_grant;
  logic [DATA_WIDTH-1:0]     mux_data;
  logic [ROB_ENTRY_LOG2-1:0] mux_id;
  logic [ISR_NUM_LOG2-1:0]   mux_src;

  // The slot can take a new value when it is empty or is drained this cycle.
  // Gating with RSTN keeps the grant low while the core is held in reset.
  assign slot_free  = ~valid_q | cdb_ready;
  assign arb_enable = slot_free & ~flush & RSTN;

  rr_arbiter #(.N(ISR_NUM)) u_rr (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .req    (isr_request),
    .enable (arb_enable),
    .grant  (isr_grant)
  );

  // Turn the one-hot grant into an index and select that issuer's data and id.
  always_comb begin
    any_grant = 1'b0;
    mux_data  = '0;
    mux_id    = '0;
    mux_src   = '0;
    for (int i = 0; i < ISR_NUM; i++) begin
      if (isr_grant[i]) begin
        any_grant = 1'b1;
        mux_data  = isr_data[i*DATA_WIDTH +: DATA_WIDTH];
        mux_id    = isr_id[i*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2];
        mux_src   = ISR_NUM_LOG2'(i);
      end
    end
  end

  // A grant only happens when the slot is free, so loading a new value never
  // overwrites a broadcast that has not been consumed.
  // A flush clears valid even while the ROB stalls. Data, id and src hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    src_d   = src_q;
    if (any_grant) begin
      valid_d = 1'b1;
      data_d  = mux_data;
      id_d    = mux_id;
      src_d   = mux_src;
    end else if (flush || cdb_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      src_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      src_q   <= src_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_data  = data_q;
  assign cdb_id    = id_q;
  assign cdb_src   = src_q;

endmodule
